fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters in the write-clock domain.
- Grants one requester at a time for a burst of up to BURST_LEN words.
- Throttles on the FIFO full_flag and almost_full_flag.
- Drives the FIFO valid_write and data_in through one register stage.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- SIZE, 32, data word width; must match the FIFO SIZE.
- BURST_LEN, 4, maximum number of words accepted per grant; must be >= 1.

Ports:
- clock  input  1  write-domain clock, same clock as the FIFO write_clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high while that requester has a word on req_data.
- req_data  input  NUM_REQ*SIZE  flattened request data; requester i occupies bits [i*SIZE +: SIZE].
- full_flag  input  1  FIFO full flag.
- almost_full_flag  input  1  FIFO almost-full flag.
- ack  output  NUM_REQ  one-hot, combinational; pulses in the cycle a word is accepted from that requester.
- grant  output  NUM_REQ  one-hot registered grant; all zero when no requester is granted.
- grant_id  output  $clog2(NUM_REQ)  index of the granted requester; 0 when idle.
- valid_write  output  1  registered write strobe to the FIFO.
- data_in  output  SIZE  registered write data to the FIFO.
- busy  output  1  high while in state BURST.

Behaviour:
- Reset values: state=IDLE, grant=0, grant_id=0, valid_write=0, data_in=0, busy=0, rr_ptr=0, burst_cnt=0. Reset takes effect immediately (asynchronous). A write pending in the output register is discarded.
- State IDLE:
  - If |req and !full_flag, select the first i with req[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Next cycle: grant=onehot(i), grant_id=i, burst_cnt=0, state=BURST.
  - Otherwise stay in IDLE.
  - ack is always 0 in IDLE, so a new grant costs exactly one arbitration cycle.
- Accept condition, with g = grant_id:
  - accept = (state==BURST) && req[g] && !full_flag && !(almost_full_flag && valid_write).
  - The almost_full term stops a second back-to-back write while the FIFO flag is still catching up with the previous write.
- On accept:
  - ack[g]=1 in the same cycle.
  - Next cycle: valid_write=1, data_in=req_data[g*SIZE +: SIZE], burst_cnt+1.
  - When not accepting: valid_write=0 next cycle and data_in holds its last value.
- State BURST exits to IDLE on the next edge when either condition holds:
  - (a) accept and burst_cnt==BURST_LEN-1, i.e. the BURST_LEN-th word;
  - (b) req[g]==0.
- On exit: rr_ptr = (g+1) mod NUM_REQ, grant=0, grant_id=0, burst_cnt=0.
- Stall: full_flag=1, or the almost-full term blocking, while req[g]=1 means stay in BURST with grant held and burst_cnt unchanged. There is no timeout.
- Fairness: a continuously requesting agent waits at most (NUM_REQ-1) × (BURST_LEN+1) cycles of granted service, excluding full stalls.
- Latency: req[i] high in IDLE with rr_ptr=i and FIFO not full gives grant at edge +1, ack at cycle +1, valid_write at edge +2.
- Requesters must not change req_data for the granted index except after an ack. Dropping req without an ack is legal and ends the burst.
- Non-granted requesters get no ack and need no handshake.
- burst_cnt width is $clog2(BURST_LEN+1). rr_ptr wraps from NUM_REQ-1 to 0, including non-power-of-two NUM_REQ.

Test Plan:
- Reset, then req=4'b0001 continuously, FIFO never full: grant=0001 one cycle later; ack[0] high for 4 consecutive cycles; valid_write high for 4 cycles with data_in matching; grant drops for 1 IDLE cycle, then requester 0 is re-granted.
- req=4'b1111 constant, BURST_LEN=4: grant_id sequence 0,1,2,3,0 with exactly 4 writes each; total valid_write count 16 over the first four bursts.
- Requester 2 granted, full_flag raised after its 2nd ack for 5 cycles: no ack and valid_write=0 during the stall; grant stays 0100; 2 remaining words written after full_flag falls; total 4.
- almost_full_flag=1 with back-to-back acks: acks alternate every other cycle and valid_write is never high on two consecutive edges.
- Requester 1 drops req after 2 words: burst ends; rr_ptr=2; next grant goes to requester 2 even if requester 1 re-asserts.
- reset asserted mid-burst with valid_write=1: all outputs zero immediately; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between the requesters/FIFO and the round-robin write arbiter.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int SIZE    = 32
);
   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]      req;
   logic [NUM_REQ*SIZE-1:0] req_data;
   logic                    full_flag;
   logic                    almost_full_flag;
   logic [NUM_REQ-1:0]      ack;
   logic [NUM_REQ-1:0]      grant;
   logic [IW-1:0]           grant_id;
   logic                    valid_write;
   logic [SIZE-1:0]         data_in;
   logic                    busy;

   modport slave (
      input  req, req_data, full_flag, almost_full_flag,
      output ack, grant, grant_id, valid_write, data_in, busy
   );

   modport master (
      output req, req_data, full_flag, almost_full_flag,
      input  ack, grant, grant_id, valid_write, data_in, busy
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// granting bursts of up to BURST_LEN words with full/almost-full throttling.
module fifo_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int SIZE      = 32,
   parameter int BURST_LEN = 4
) (
   input  logic               clock,
   input  logic               reset,
   fifo_write_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
   localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, BURST} state_t;

   state_t                       state_q;
   logic [NUM_REQ-1:0]           grant_q;
   logic [IW-1:0]                grant_id_q;
   logic [IW-1:0]                rr_ptr_q;
   logic [CW-1:0]                burst_cnt_q;
   logic                         valid_q;
   logic [SIZE-1:0]              data_q;

   logic [NUM_REQ-1:0][SIZE-1:0] lane_data;
   logic [IW-1:0]                sel_d;
   logic [IW-1:0]                next_ptr;
   logic                         accept;
   logic                         last_word;

   assign lane_data = bus.req_data;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      return IW'((s >= NUM_REQ) ? s - NUM_REQ : s);
   endfunction

   // Walk from the far end back to rr_ptr so the closest requester wins.
   always_comb begin
      sel_d = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[rr_idx(rr_ptr_q, k)]) sel_d = rr_idx(rr_ptr_q, k);
      end
   end

   // The almost-full term blocks a second write while the flag may still lag the first.
   assign accept    = (state_q == BURST) && bus.req[grant_id_q] && !bus.full_flag
                      && !(bus.almost_full_flag && valid_q);
   assign last_word = accept && (burst_cnt_q == LAST_CNT);
   assign next_ptr  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IW'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
      end else begin
         valid_q <= accept;
         if (accept) data_q <= lane_data[grant_id_q];
         case (state_q)
            IDLE: begin
               if (|bus.req && !bus.full_flag) begin
                  state_q     <= BURST;
                  grant_q     <= ONE << sel_d;
                  grant_id_q  <= sel_d;
                  burst_cnt_q <= '0;
               end
            end
            BURST: begin
               if (last_word || !bus.req[grant_id_q]) begin
                  state_q     <= IDLE;
                  grant_q     <= '0;
                  grant_id_q  <= '0;
                  burst_cnt_q <= '0;
                  rr_ptr_q    <= next_ptr;
               end else if (accept) begin
                  burst_cnt_q <= burst_cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ack         = accept ? grant_q : '0;
   assign bus.grant       = grant_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.valid_write = valid_q;
   assign bus.data_in     = data_q;
   assign bus.busy        = (state_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of the arbitration rules.
module tb_fifo_write_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int BL = 4;
   localparam int VW = 2 * N + 2 + 1 + W + 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   fifo_write_arbiter_if #(.NUM_REQ(N), .SIZE(W)) bus ();
   fifo_write_arbiter #(.NUM_REQ(N), .SIZE(W), .BURST_LEN(BL)) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );

   int passed = 0;
   int total  = 0;
   logic [N-1:0] last_ack;

   // Model: who owns the port, how many words taken, where the search starts next.
   bit           m_busy, m_vw;
   int           m_g, m_cnt, m_ptr;
   logic [W-1:0] m_data;

   function automatic bit m_accept();
      return m_busy && bus.req[m_g] && !bus.full_flag && !(bus.almost_full_flag && m_vw);
   endfunction

   always @(posedge clock or posedge reset) begin : model
      bit acc;
      int pick;
      if (reset) begin
         m_busy <= 0; m_vw <= 0; m_g <= 0; m_cnt <= 0; m_ptr <= 0; m_data <= '0;
      end else begin
         acc = m_accept();
         m_vw <= acc;
         if (acc) m_data <= bus.req_data[m_g*W +: W];
         if (m_busy) begin
            if ((acc && m_cnt + 1 == BL) || !bus.req[m_g]) begin
               m_busy <= 0; m_cnt <= 0; m_ptr <= (m_g + 1) % N;
            end else if (acc) m_cnt <= m_cnt + 1;
         end else if (bus.req != 0 && !bus.full_flag) begin
            pick = -1;
            for (int k = 0; k < N; k++)
               if (pick < 0 && bus.req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            m_busy <= 1; m_g <= pick; m_cnt <= 0;
         end
      end
   end

   function automatic logic [VW-1:0] exp_vec();
      logic [N-1:0] oh;
      logic [1:0]   gid;
      oh  = '0;
      gid = '0;
      if (m_busy) begin
         oh[m_g] = 1'b1;
         gid     = m_g[1:0];
      end
      return {m_accept() ? oh : {N{1'b0}}, oh, gid, m_vw, m_data, m_busy};
   endfunction

   logic [VW-1:0] dut_vec;
   assign dut_vec = {bus.ack, bus.grant, bus.grant_id, bus.valid_write, bus.data_in, bus.busy};

   task automatic drive_data();
      for (int i = 0; i < N; i++)
         if (!(m_busy && m_g == i) || last_ack[i]) bus.req_data[i*W +: W] = $urandom();
   endtask

   task automatic nxt();
      last_ack = bus.ack;
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req = '0; bus.full_flag = 1'b0; bus.almost_full_flag = 1'b0;
      last_ack = '0;
      drive_data();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req = '1;
      #2;
      total++;
      if (dut_vec !== '0) $display("FAIL reset_outputs got %h exp 0", dut_vec); else passed++;
      do_reset();
      bus.req = '0;
      #2;
      total++;
      if (dut_vec !== exp_vec() || dut_vec !== '0)
         $display("FAIL reset_idle got %h exp %h", dut_vec, exp_vec());
      else passed++;
      nxt();
   endtask

   task automatic test_single();
      int acks = 0, vws = 0, idles = 0;
      do_reset();
      for (int c = 0; c < 11; c++) begin
         bus.req = 4'b0001; drive_data(); #2;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL single_model c=%0d got %h exp %h", c, dut_vec, exp_vec());
         else passed++;
         acks += int'(bus.ack[0]); vws += int'(bus.valid_write); idles += int'(bus.grant == 0);
         nxt();
      end
      total++; if (acks !== 8) $display("FAIL single_acks got %0d exp 8", acks); else passed++;
      total++; if (vws !== 8) $display("FAIL single_writes got %0d exp 8", vws); else passed++;
      total++; if (idles !== 3) $display("FAIL single_idle got %0d exp 3", idles); else passed++;
   endtask

   task automatic test_round_robin();
      int seq[$];
      int per[N];
      int vws = 0;
      logic [N-1:0] prev = '0;
      do_reset();
      for (int i = 0; i < N; i++) per[i] = 0;
      for (int c = 0; c < 21; c++) begin
         bus.req = 4'b1111; drive_data(); #2;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL rr_model c=%0d got %h exp %h", c, dut_vec, exp_vec());
         else passed++;
         if (bus.grant != 0 && prev == 0) seq.push_back(int'(bus.grant_id));
         for (int i = 0; i < N; i++) per[i] += int'(bus.ack[i]);
         vws += int'(bus.valid_write);
         prev = bus.grant;
         nxt();
      end
      total++; if (seq.size() !== 4) $display("FAIL rr_grants got %0d exp 4", seq.size()); else passed++;
      for (int k = 0; k < seq.size(); k++) begin
         total++; if (seq[k] !== k % N) $display("FAIL rr_order k=%0d got %0d exp %0d", k, seq[k], k % N); else passed++;
      end
      for (int i = 0; i < N; i++) begin
         total++; if (per[i] !== BL) $display("FAIL rr_words id=%0d got %0d exp %0d", i, per[i], BL); else passed++;
      end
      total++; if (vws !== 16) $display("FAIL rr_total got %0d exp 16", vws); else passed++;
   endtask

   task automatic test_full_stall();
      int acks = 0;
      do_reset();
      for (int c = 0; c < 11; c++) begin
         bus.req = 4'b0100; bus.full_flag = (c >= 3 && c <= 7); drive_data(); #2;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL full_model c=%0d got %h exp %h", c, dut_vec, exp_vec());
         else passed++;
         if (c >= 3 && c <= 7) begin
            total++;
            if (bus.ack !== 4'b0000 || bus.grant !== 4'b0100)
               $display("FAIL full_hold c=%0d ack %b grant %b exp 0000 0100", c, bus.ack, bus.grant);
            else passed++;
         end
         if (c >= 4 && c <= 7) begin
            total++; if (bus.valid_write !== 1'b0) $display("FAIL full_vw c=%0d got %b exp 0", c, bus.valid_write); else passed++;
         end
         acks += int'(bus.ack[2]);
         nxt();
      end
      bus.full_flag = 1'b0;
      total++; if (acks !== 4) $display("FAIL full_words got %0d exp 4", acks); else passed++;
   endtask

   task automatic test_almost_full();
      int acks = 0;
      logic pv = 1'b0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         bus.req = 4'b0010; bus.almost_full_flag = 1'b1; drive_data(); #2;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL af_model c=%0d got %h exp %h", c, dut_vec, exp_vec());
         else passed++;
         total++;
         if (bus.ack[1] !== (c % 2 == 1)) $display("FAIL af_ack c=%0d got %b exp %b", c, bus.ack[1], c % 2 == 1);
         else passed++;
         total++;
         if (pv && bus.valid_write) $display("FAIL af_b2b c=%0d got 1 exp 0", c); else passed++;
         pv = bus.valid_write;
         acks += int'(bus.ack[1]);
         nxt();
      end
      bus.almost_full_flag = 1'b0;
      total++; if (acks !== 6) $display("FAIL af_acks got %0d exp 6", acks); else passed++;
   endtask

   task automatic test_drop();
      int acks = 0;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         bus.req = (c < 3) ? 4'b0010 : (c == 3) ? 4'b0100 : 4'b0110;
         drive_data(); #2;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL drop_model c=%0d got %h exp %h", c, dut_vec, exp_vec());
         else passed++;
         if (c == 5) begin
            total++;
            if (bus.grant_id !== 2'd2 || bus.grant !== 4'b0100)
               $display("FAIL drop_next id %0d grant %b exp 2 0100", bus.grant_id, bus.grant);
            else passed++;
         end
         acks += int'(bus.ack[1]);
         nxt();
      end
      total++; if (acks !== 2) $display("FAIL drop_words got %0d exp 2", acks); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         bus.req = 4'b0100; drive_data(); #2;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL rmid_model c=%0d got %h exp %h", c, dut_vec, exp_vec());
         else passed++;
         if (c < 2) nxt();
      end
      total++; if (bus.valid_write !== 1'b1) $display("FAIL rmid_pre got %b exp 1", bus.valid_write); else passed++;
      #1 reset = 1'b1;
      #1;
      total++; if (dut_vec !== '0) $display("FAIL rmid_async got %h exp 0", dut_vec); else passed++;
      @(negedge clock);
      reset = 1'b0;
      last_ack = '0;
      for (int c = 0; c < 2; c++) begin
         bus.req = 4'b1111; drive_data(); #2;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL rmid_model2 c=%0d got %h exp %h", c, dut_vec, exp_vec());
         else passed++;
         if (c == 1) begin
            total++;
            if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0)
               $display("FAIL rmid_restart grant %b id %0d exp 0001 0", bus.grant, bus.grant_id);
            else passed++;
         end
         nxt();
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r = '0;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) r[i] = ~r[i];
         bus.req = r;
         bus.full_flag = ($urandom_range(7) == 0);
         bus.almost_full_flag = ($urandom_range(3) == 0);
         drive_data(); #2;
         total++;
         if (dut_vec !== exp_vec()) $display("FAIL rand_model c=%0d got %h exp %h", c, dut_vec, exp_vec());
         else passed++;
         nxt();
      end
   endtask

   initial begin
      bus.req = '0; bus.req_data = '0; bus.full_flag = 1'b0; bus.almost_full_flag = 1'b0;
      last_ack = '0;
      @(negedge clock);
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_almost_full();
      test_drop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
